// File: rtl/led_sequence_checker.sv
// Consumer-side monitor for the shared blinky counter bus.
// Verifies +1 mod 2^BITS steps, one every 2^LOG2DELAY clocks.

package pkg;
  localparam int BITS      = 4;
  localparam int LOG2DELAY = 22;
endpackage

module led_sequence_checker #(
  parameter int BITS       = pkg::BITS,
  parameter int LOG2DELAY  = pkg::LOG2DELAY,
  parameter int LOCK_STEPS = 2 ** BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] led,
  input  logic            clear,
  output logic            locked,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [15:0]     step_cnt
);

  localparam int GW = LOG2DELAY + 2;

  localparam logic [GW-1:0] GAP_EARLY =
    GW'((2 ** LOG2DELAY) - 1);
  localparam logic [GW-1:0] GAP_STALL =
    GW'(2 ** (LOG2DELAY + 1));

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_VAL   = 2'd1;
  localparam logic [1:0] C_STALL = 2'd2;
  localparam logic [1:0] C_EARLY = 2'd3;

  typedef enum logic [1:0] {
    ACQ,
    SYNC,
    TRACK,
    FLT
  } state_t;

  logic [1:0]      rst_sync_q;
  logic [1:0]      rst_sync_d;
  logic            rst_i;

  logic [BITS-1:0] led_q;
  logic [BITS-1:0] led_d;
  logic [BITS-1:0] prev_q;
  logic [BITS-1:0] prev_d;
  logic [GW-1:0]   gap_q;
  logic [GW-1:0]   gap_d;
  state_t          state_q;
  state_t          state_d;
  logic [15:0]     cnt_q;
  logic [15:0]     cnt_d;
  logic [1:0]      code_q;
  logic [1:0]      code_d;
  logic            locked_q;
  logic            locked_d;
  logic            fault_q;
  logic            fault_d;

  logic            chg;
  logic [BITS-1:0] prev_nxt;
  logic [GW-1:0]   gap_inc;
  logic [15:0]     cnt_inc;

  // Release synchronizer: assert at once, release after two edges
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b0};
  end

  // Release synchronizer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_i = rst_sync_q[1];

  // Next-state, checks and registered-output values
  always_comb begin
    led_d    = led;
    chg      = (led_q != prev_q);
    prev_nxt = prev_q + BITS'(1);
    gap_inc  = (gap_q == '1) ? gap_q : gap_q + GW'(1);
    cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    state_d  = state_q;
    prev_d   = prev_q;
    gap_d    = gap_inc;
    cnt_d    = cnt_q;
    code_d   = code_q;

    if (clear) begin
      state_d = ACQ;
      gap_d   = '0;
      cnt_d   = '0;
      code_d  = C_NONE;
    end else begin
      case (state_q)
        ACQ: begin
          if (chg) begin
            prev_d  = led_q;
            gap_d   = '0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (chg) begin
            if (led_q == prev_nxt) begin
              prev_d  = led_q;
              gap_d   = '0;
              cnt_d   = 16'd1;
              state_d = TRACK;
            end else begin
              state_d = FLT;
              code_d  = C_VAL;
            end
          end else if (gap_q == GAP_STALL) begin
            state_d = FLT;
            code_d  = C_STALL;
          end
        end
        TRACK: begin
          if (chg) begin
            if (led_q != prev_nxt) begin
              state_d = FLT;
              code_d  = C_VAL;
            end else if (gap_q < GAP_EARLY) begin
              state_d = FLT;
              code_d  = C_EARLY;
            end else begin
              prev_d = led_q;
              gap_d  = '0;
              cnt_d  = cnt_inc;
            end
          end else if (gap_q == GAP_STALL) begin
            state_d = FLT;
            code_d  = C_STALL;
          end
        end
        FLT: begin
          state_d = FLT;
        end
        default: begin
          state_d = ACQ;
        end
      endcase
    end

    fault_d  = (state_d == FLT);
    locked_d = (state_d == TRACK) &&
               (int'(cnt_d) >= LOCK_STEPS);
  end

  // State, tracking and status registers
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      led_q    <= '0;
      prev_q   <= '0;
      gap_q    <= '0;
      state_q  <= ACQ;
      cnt_q    <= '0;
      code_q   <= C_NONE;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      led_q    <= led_d;
      prev_q   <= prev_d;
      gap_q    <= gap_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
    end
  end

  assign locked     = locked_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign step_cnt   = cnt_q;

endmodule

// File: tb/tb_led_sequence_checker.sv
// Scoreboard bench for led_sequence_checker.
// BITS=4, LOG2DELAY=3 (nominal period 8 clocks).

module tb_led_sequence_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  led;
  logic        locked;
  logic        fault;
  logic [1:0]  fault_code;
  logic [15:0] step_cnt;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int          cyc;
    string       nm;
    logic        l;
    logic        f;
    logic [1:0]  c;
    logic [15:0] s;
  } exp_t;

  exp_t q[$];

  led_sequence_checker #(
    .BITS(4),
    .LOG2DELAY(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .led(led),
    .clear(clear),
    .locked(locked),
    .fault(fault),
    .fault_code(fault_code),
    .step_cnt(step_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter used to schedule expectations
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop every expectation due at this cycle and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_chk++;
        if (e.cyc != cyc) begin
          $display("FAIL %s: missed, due cycle %0d, now %0d",
                   e.nm, e.cyc, cyc);
        end else if ({locked, fault, fault_code, step_cnt} !==
                     {e.l, e.f, e.c, e.s}) begin
          $display("FAIL %s @%0d: got l=%0b f=%0b c=%0d n=%0d want l=%0b f=%0b c=%0d n=%0d",
                   e.nm, cyc, locked, fault, fault_code, step_cnt,
                   e.l, e.f, e.c, e.s);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int dly, input string nm,
                           input logic l, input logic f,
                           input logic [1:0] c,
                           input logic [15:0] s);
    exp_t e;
    e.cyc = cyc + dly;
    e.nm  = nm;
    e.l   = l;
    e.f   = f;
    e.c   = c;
    e.s   = s;
    q.push_back(e);
  endtask

  task automatic step(input logic [3:0] v, input int wt,
                      input string nm, input logic l,
                      input logic f, input logic [1:0] c,
                      input logic [15:0] s);
    tick(wt);
    led = v;
    expect_at(2, nm, l, f, c, s);
  endtask

  // Ideal counter from 1: first change loads, second enters tracking
  task automatic acquire(input int n);
    int s;
    for (int i = 1; i <= n; i++) begin
      s = (i >= 2) ? i - 1 : 0;
      step(4'(i), (i == 1) ? 0 : 8, "acquire",
           s >= 16, 1'b0, 2'd0, 16'(s));
    end
  endtask

  task automatic restart();
    rst = 1'b1;
    led = 4'd0;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    led   = 4'd0;
    tick(3);
    expect_at(0, "rst_hold", 0, 0, 2'd0, 16'd0);
    rst = 1'b0;
    tick(4);
    expect_at(0, "rst_release", 0, 0, 2'd0, 16'd0);

    acquire(53);

    tick(8);
    led = 4'd7;
    expect_at(1, "bad_latency", 1, 0, 2'd0, 16'd52);
    expect_at(2, "bad_value", 0, 1, 2'd1, 16'd52);
    tick(20);
    expect_at(0, "bad_sticky", 0, 1, 2'd1, 16'd52);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    expect_at(0, "clear", 0, 0, 2'd0, 16'd0);
    tick(6);
    expect_at(0, "clear_hold", 0, 0, 2'd0, 16'd0);

    restart();
    acquire(9);
    expect_at(18, "stall_pre", 0, 0, 2'd0, 16'd8);
    expect_at(19, "stall", 0, 1, 2'd2, 16'd8);
    tick(22);

    restart();
    acquire(9);
    step(4'd10, 17, "stall_edge", 0, 0, 2'd0, 16'd9);
    step(4'd11, 4, "early", 0, 1, 2'd3, 16'd9);
    tick(4);

    restart();
    acquire(17);
    tick(3);
    expect_at(0, "locked_hold", 1, 0, 2'd0, 16'd16);
    tick(1);
    rst = 1'b1;
    led = 4'd0;
    expect_at(0, "async_rst", 0, 0, 2'd0, 16'd0);
    tick(2);
    rst = 1'b0;
    tick(4);
    acquire(17);
    tick(4);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      $display("FAIL %s: never checked, due cycle %0d",
               e.nm, e.cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
